// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, funct codes, CSR addresses, trap causes and ALU helper
// shared by the single-cycle RV32I core and its memory.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [6:0] F7_SFVMA = 7'b0001001;

    localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INS_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INS_MRET   = 32'h3020_0073;
    localparam logic [31:0] INS_SRET   = 32'h1020_0073;
    localparam logic [31:0] INS_WFI    = 32'h1050_0073;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;
    localparam logic [11:0] CSR_SEPC   = 12'h141;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_BREAK   = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} ls_size_e;

    function automatic ls_size_e size_of(input logic [2:0] f3);
        ls_size_e s;
        s = SZ_X;
        unique case (f3)
            3'd0, 3'd4: s = SZ_B;
            3'd1, 3'd5: s = SZ_H;
            3'd2:       s = SZ_W;
            default:    s = SZ_X;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic signed [31:0] sa;
        r = '0;
        sa = a;
        unique case (f3)
            F3_ADD:  r = alt ? a - b : a + b;
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            F3_SLTU: r = {31'd0, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR: begin
                if (alt) r = sa >>> b[4:0];
                else     r = a >> b[4:0];
            end
            F3_OR:   r = a | b;
            F3_AND:  r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32_if.sv
// rv32_if: core-to-memory bus with a fetch read port, a data read port
// and a byte-masked data write port.
interface rv32_if;
    logic [31:0] f_addr;
    logic [31:0] f_rdata;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;

    modport master (output f_addr, d_addr, wdata, be, we,
                    input  f_rdata, d_rdata);
    modport slave  (input  f_addr, d_addr, wdata, be, we,
                    output f_rdata, d_rdata);
endinterface

// File: rtl/rv32_mem.sv
// rv32_mem: unified word memory, two combinational read ports and one
// synchronous byte-masked write port; address bits above the depth wrap.
module rv32_mem #(
    parameter int MEM_WORDS = 65536
) (
    input logic   clk,
    rv32_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] m [0:MEM_WORDS-1];
    logic        unused_bits;

    assign bus.f_rdata = m[bus.f_addr[AW+1:2]];
    assign bus.d_rdata = m[bus.d_addr[AW+1:2]];
    assign unused_bits = ^{bus.f_addr[31:AW+2], bus.f_addr[1:0],
                           bus.d_addr[31:AW+2], bus.d_addr[1:0]};

    always_ff @(posedge clk) begin
        if (bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) m[bus.d_addr[AW+1:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I + Zicsr core with machine-mode traps.
// Define CORE_TRACE_EN to print one trace line per retired instruction.
module rv32_core
    import rv32_pkg::*;
#(
    parameter int          MEM_WORDS = 65536,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    output logic [31:0] gp_o
);
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] rs  [0:31];
    logic [31:0] csr [0:4095];

    rv32_if bus ();

    rv32_mem #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk (clk),
        .bus (bus.slave)
    );

    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] csr_old, csr_src, half_v;
    logic [7:0]  byte_v;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, ra1, ra2;
    logic [2:0]  f3;
    logic [11:0] csr_a;
    ls_size_e    sz;

    logic        rd_we, csr_we, trap, ill, take;
    logic [31:0] rd_val, csr_wval, cause, tval;

    assign ins   = bus.f_rdata;
    assign opc   = ins[6:0];
    assign rd    = ins[11:7];
    assign f3    = ins[14:12];
    assign ra1   = ins[19:15];
    assign ra2   = ins[24:20];
    assign f7    = ins[31:25];
    assign csr_a = ins[31:20];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'd0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    assign a = (ra1 == 5'd0) ? 32'd0 : rs[ra1];
    assign b = (ra2 == 5'd0) ? 32'd0 : rs[ra2];

    assign csr_old = csr[csr_a];
    assign csr_src = f3[2] ? {27'd0, ra1} : a;
    assign sz      = size_of(f3);

    assign bus.f_addr = pc;
    assign bus.d_addr = a + ((opc == OP_STORE) ? imm_s : imm_i);
    assign byte_v     = bus.d_rdata[{bus.d_addr[1:0], 3'b000} +: 8];
    assign half_v     = {16'd0, bus.d_addr[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0]};

    assign pc_o = pc;
    assign gp_o = rs[3];

    always_comb begin
        pc_d      = pc + 32'd4;
        rd_we     = 1'b0;
        rd_val    = '0;
        csr_we    = 1'b0;
        csr_wval  = '0;
        ill       = 1'b0;
        trap      = 1'b0;
        take      = 1'b0;
        cause     = '0;
        tval      = '0;
        bus.we    = 1'b0;
        bus.be    = '0;
        bus.wdata = '0;
        unique case (opc)
            OP_LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            OP_AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            OP_JAL: begin
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                pc_d   = pc + imm_j;
            end
            OP_JALR: begin
                ill    = (f3 != 3'd0);
                rd_we  = 1'b1;
                rd_val = pc + 32'd4;
                pc_d   = (a + imm_i) & ~32'd1;
            end
            OP_BRANCH: begin
                unique case (f3)
                    F3_BEQ:  take = (a == b);
                    F3_BNE:  take = (a != b);
                    F3_BLT:  take = $signed(a) < $signed(b);
                    F3_BGE:  take = $signed(a) >= $signed(b);
                    F3_BLTU: take = a < b;
                    F3_BGEU: take = a >= b;
                    default: ill = 1'b1;
                endcase
                if (take) pc_d = pc + imm_b;
            end
            OP_LOAD: begin
                rd_we = 1'b1;
                unique case (f3)
                    F3_LB:   rd_val = {{24{byte_v[7]}}, byte_v};
                    F3_LH:   rd_val = {{16{half_v[15]}}, half_v[15:0]};
                    F3_LW:   rd_val = bus.d_rdata;
                    F3_LBU:  rd_val = {24'd0, byte_v};
                    F3_LHU:  rd_val = half_v;
                    default: ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                bus.we = !f3[2];
                ill    = f3[2];
                unique case (sz)
                    SZ_B: begin
                        bus.be    = 4'b0001 << bus.d_addr[1:0];
                        bus.wdata = {4{b[7:0]}};
                    end
                    SZ_H: begin
                        bus.be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                        bus.wdata = {2{b[15:0]}};
                    end
                    SZ_W: begin
                        bus.be    = 4'b1111;
                        bus.wdata = b;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_IMM: begin
                ill = (f3 == F3_SLL && f7 != F7_BASE) ||
                      (f3 == F3_SR && f7 != F7_BASE && f7 != F7_ALT);
                rd_we  = 1'b1;
                rd_val = alu(f3, f3 == F3_SR && f7[5], a, imm_i);
            end
            OP_OP: begin
                ill = !(f7 == F7_BASE ||
                        (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
                rd_we  = 1'b1;
                rd_val = alu(f3, f7[5], a, b);
            end
            OP_FENCE: ill = (f3[2:1] != 2'd0);
            OP_SYSTEM: begin
                if (f3 == 3'd0) begin
                    unique case (1'b1)
                        ins == INS_ECALL: begin
                            trap  = 1'b1;
                            cause = CAUSE_ECALL;
                        end
                        ins == INS_EBREAK: begin
                            trap  = 1'b1;
                            cause = CAUSE_BREAK;
                        end
                        ins == INS_MRET: pc_d = csr[CSR_MEPC];
                        ins == INS_SRET: pc_d = csr[CSR_SEPC];
                        ins == INS_WFI: begin end
                        (f7 == F7_SFVMA && ins[14:7] == 8'd0): begin end
                        default: ill = 1'b1;
                    endcase
                end else if (f3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    // Old value goes to rd; set/clear with a zero source leave the CSR alone
                    rd_we  = 1'b1;
                    rd_val = csr_old;
                    unique case (f3[1:0])
                        2'b01: begin
                            csr_we   = 1'b1;
                            csr_wval = csr_src;
                        end
                        2'b10: begin
                            csr_we   = (ra1 != 5'd0);
                            csr_wval = csr_old | csr_src;
                        end
                        default: begin
                            csr_we   = (ra1 != 5'd0);
                            csr_wval = csr_old & ~csr_src;
                        end
                    endcase
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            trap  = 1'b1;
            cause = CAUSE_ILLEGAL;
            tval  = ins;
        end
        if (trap) begin
            pc_d   = {csr[CSR_MTVEC][31:2], 2'b00};
            rd_we  = 1'b0;
            csr_we = 1'b0;
            bus.we = 1'b0;
        end
        if (rst) bus.we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) rs[i] <= '0;
            for (int i = 0; i < 4096; i++) csr[i] <= '0;
        end else begin
            pc <= pc_d;
            if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
            if (csr_we) csr[csr_a] <= csr_wval;
            if (trap) begin
                csr[CSR_MEPC]   <= pc;
                csr[CSR_MCAUSE] <= cause;
                csr[CSR_MTVAL]  <= tval;
            end
        end
    end

`ifdef CORE_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            $display("pc=%08h ins=%08h rd=x%0d val=%08h", pc, ins,
                     (rd_we && rd != 5'd0) ? rd : 5'd0,
                     (rd_we && rd != 5'd0) ? rd_val : 32'd0);
            if (trap) $display("trap cause=%0d", cause);
        end
    end
`else
    // Trace output is compiled out in this build.
`endif

endmodule

// File: tb/tb_rv32_core.sv
// tb_rv32_core: directed programs plus a random ALU/load/store stream
// checked against an instruction-level reference model.
module tb_rv32_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] gp_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] r  [32];
    logic [7:0]  mb [1024];
    int          lf3 [5] = '{0, 1, 2, 4, 5};

    rv32_core dut (
        .clk  (clk),
        .rst  (rst),
        .pc_o (pc_o),
        .gp_o (gp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] ins);
        dut.memory.m[addr[17:2]] = ins;
    endtask

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd, logic [31:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2, logic [31:0] rs1,
                                          logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2,
                                          logic [31:0] rs1, logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd, logic [31:0] op);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] off, logic [31:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] off, logic [31:0] rs2,
                                          logic [31:0] rs1, logic [31:0] f3);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:1], off[11], 7'h63};
    endfunction

    function automatic logic [31:0] sext12(logic [31:0] v);
        return {{20{v[11]}}, v[11:0]};
    endfunction

    // ISA-level meaning of the eight OP/OP-IMM functions
    function automatic logic [31:0] ref_op(int f3, bit alt, logic [31:0] x, logic [31:0] y);
        int          sh;
        logic [63:0] wide;
        sh   = int'(y & 32'd31);
        wide = {{32{x[31]}}, x} >> sh;
        case (f3)
            0: return alt ? x - y : x + y;
            1: return x << sh;
            2: return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            3: return (x < y) ? 32'd1 : 32'd0;
            4: return x ^ y;
            5: return alt ? wide[31:0] : x >> sh;
            6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [31:0] ld_ref(int f3, int o);
        logic [7:0]  bv;
        logic [15:0] hv;
        int          h;
        int          w;
        h  = o & ~1;
        w  = o & ~3;
        bv = mb[o];
        hv = {mb[h+1], mb[h]};
        case (f3)
            0: return {{24{bv[7]}}, bv};
            1: return {{16{hv[15]}}, hv};
            2: return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
            4: return {24'd0, bv};
            default: return {16'd0, hv};
        endcase
    endfunction

    task automatic st_ref(input int f3, input int o, input logic [31:0] v);
        int base;
        int n;
        n    = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        base = o & ~(n - 1);
        for (int i = 0; i < n; i++) mb[base+i] = v[8*i +: 8];
    endtask

    initial begin
        logic [31:0] ins, x, y, v, imm, addr, cur_pc;
        int          rd, r1, r2, f3, kind, o, wo, found;
        bit          alt, st;

        for (int i = 0; i < 512; i++) dut.memory.m[i] = 32'h0;

        // Program A: basic ALU, x0, memory, csr, ecall, mret
        put('h00, enc_i(1, 0, 0, 3, 'h13));
        put('h04, enc_i(5, 0, 0, 0, 'h13));
        put('h08, enc_u('h11223, 5, 'h37));
        put('h0C, enc_i('h344, 5, 0, 5, 'h13));
        put('h10, enc_s('h100, 5, 0, 2));
        put('h14, enc_i('h40, 0, 0, 10, 'h13));
        put('h18, enc_i('h305, 10, 1, 0, 'h73));
        put('h1C, enc_i('h103, 0, 0, 6, 'h03));
        put('h20, 'h00000073);
        put('h40, enc_i('h102, 0, 5, 7, 'h03));
        put('h44, enc_i('h342, 0, 2, 11, 'h73));
        put('h48, 'h30200073);

        do_reset();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_gp", gp_o, 32'h0);
        for (int i = 1; i < 32; i++) chk($sformatf("rst_x%0d", i), dut.rs[i], 32'h0);

        step();
        chk("addi_gp", gp_o, 32'd1);
        chk("addi_pc", pc_o, 32'h4);
        step();
        chk("x0_zero", dut.rs[0], 32'h0);
        step();
        step();
        chk("lui_addi", dut.rs[5], 32'h11223344);
        step();
        chk("sw_mem", dut.memory.m[32'h40], 32'h11223344);
        step();
        step();
        chk("csrrw_mtvec", dut.csr[12'h305], 32'h40);
        step();
        chk("lb_x6", dut.rs[6], 32'h00000011);
        step();
        chk("ecall_pc", pc_o, 32'h40);
        chk("ecall_mepc", dut.csr[12'h341], 32'h20);
        chk("ecall_mcause", dut.csr[12'h342], 32'd11);
        chk("ecall_mtval", dut.csr[12'h343], 32'h0);
        step();
        chk("lhu_x7", dut.rs[7], 32'h00001122);
        step();
        chk("csrrs_rd", dut.rs[11], 32'd11);
        chk("csrrs_keep", dut.csr[12'h342], 32'd11);
        step();
        chk("mret_pc", pc_o, 32'h20);

        // Program B: illegal instruction trap
        put('h00, enc_i('h40, 0, 0, 10, 'h13));
        put('h04, enc_i('h305, 10, 1, 0, 'h73));
        put('h08, 'hFFFFFFFF);
        do_reset();
        chk("rstb_mtvec", dut.csr[12'h305], 32'h0);
        step();
        step();
        step();
        chk("ill_pc", pc_o, 32'h40);
        chk("ill_mcause", dut.csr[12'h342], 32'd2);
        chk("ill_mtval", dut.csr[12'h343], 32'hFFFFFFFF);
        chk("ill_mepc", dut.csr[12'h341], 32'h8);
        chk("ill_no_wb", dut.rs[31], 32'h0);

        // Program C: random straight-line stream against the model
        do_reset();
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'h0;
        for (int i = 256; i < 512; i++) dut.memory.m[i] = 32'h0;
        cur_pc = 32'h0;
        for (int k = 0; k < 80; k++) begin
            kind = int'($urandom_range(0, 5));
            rd   = int'($urandom_range(0, 31));
            r1   = int'($urandom_range(0, 31));
            r2   = int'($urandom_range(0, 31));
            f3   = int'($urandom_range(0, 7));
            imm  = $urandom & 32'hFFF;
            addr = 32'h400 + ($urandom & 32'h3FF);
            o    = int'(addr) - 'h400;
            x    = r[r1];
            y    = r[r2];
            st   = 1'b0;
            alt  = 1'b0;
            v    = 32'h0;
            case (kind)
                0: begin
                    imm = $urandom & 32'hFFFFF;
                    ins = enc_u(imm, rd, 'h37);
                    v   = imm << 12;
                end
                1: begin
                    if (f3 == 1) imm = imm & 32'h1F;
                    if (f3 == 5) begin
                        alt = 1'($urandom_range(0, 1));
                        imm = (imm & 32'h1F) | (alt ? 32'h400 : 32'h0);
                    end
                    ins = enc_i(imm, r1, f3, rd, 'h13);
                    v   = ref_op(f3, alt, x, sext12(imm));
                end
                2: begin
                    alt = (f3 == 0 || f3 == 5) && ($urandom_range(0, 1) == 1);
                    ins = enc_r(alt ? 'h20 : 'h00, r2, r1, f3, rd);
                    v   = ref_op(f3, alt, x, y);
                end
                3: begin
                    imm = $urandom & 32'hFFFFF;
                    ins = enc_u(imm, rd, 'h17);
                    v   = cur_pc + (imm << 12);
                end
                4: begin
                    f3  = int'($urandom_range(0, 2));
                    ins = enc_s(addr, r2, 0, f3);
                    st_ref(f3, o, y);
                    st  = 1'b1;
                end
                default: begin
                    f3  = lf3[$urandom_range(0, 4)];
                    ins = enc_i(addr, 0, f3, rd, 'h03);
                    v   = ld_ref(f3, o);
                end
            endcase
            put(cur_pc, ins);
            step();
            cur_pc = cur_pc + 32'd4;
            if (st) begin
                wo = o & ~3;
                chk("rnd_store", dut.memory.m[addr[17:2]],
                    {mb[wo+3], mb[wo+2], mb[wo+1], mb[wo]});
            end else begin
                if (rd != 0) r[rd] = v;
                chk($sformatf("rnd_x%0d", rd), dut.rs[rd], r[rd]);
            end
            chk("rnd_pc", pc_o, cur_pc);
        end

        // Program D: wfi/fence/branch loop ending in a pass loop at 0x44
        put('h00, enc_i(5, 0, 0, 1, 'h13));
        put('h04, 'h10500073);
        put('h08, 'h0FF0000F);
        put('h0C, enc_i('hFFF, 1, 0, 1, 'h13));
        put('h10, enc_b(-8, 0, 1, 1));
        put('h14, enc_j('h2C, 4));
        put('h40, enc_i(1, 0, 0, 3, 'h13));
        put('h44, enc_j(0, 0));
        do_reset();
        found = 0;
        for (int c = 0; c < 5000; c++) begin
            step();
            if (pc_o == 32'h44 && gp_o == 32'd1) begin
                found = 1;
                break;
            end
        end
        chk("wfi_pass", found, 32'd1);
        chk("loop_x1", dut.rs[1], 32'h0);
        chk("jal_link", dut.rs[4], 32'h18);
        step();
        chk("self_loop", pc_o, 32'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
